// File: rtl/ntt_bram_sdp.sv
// Simple-dual-port coefficient RAM for the NTT kernel: strobed lane writes, 1/2-cycle
// registered reads with RVALID, optional write-first bypass and a whole-array clear engine.
module ntt_bram_sdp #(
   parameter int DW         = 128,
   parameter int WL         = 32,
   parameter int AW         = 13,
   parameter int ADDR_SHIFT = 2,
   parameter int RD_LAT     = 1,
   parameter int BYPASS     = 1
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               CLR,
   output logic               BUSY,
   output logic               CLR_DONE,
   input  logic               WEN,
   input  logic [DW/32-1:0]   WSTRB,
   input  logic [AW-1:0]      WA,
   input  logic [DW-1:0]      WD,
   input  logic               REN,
   input  logic [AW-1:0]      RA,
   output logic [DW-1:0]      RD,
   output logic               RVALID
);

   localparam int L  = DW / 32;
   localparam int IW = (WL > 1) ? $clog2(WL) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rd1_q, rd1_d;
   logic          rv1_q, rv1_d;

   logic [IW-1:0] widx, ridx;
   logic          wr_acc, rd_acc, collide, clr_we;
   logic [DW-1:0] rd_pre;

   assign BUSY     = (state_q != S_IDLE);
   assign CLR_DONE = (state_q == S_DONE);
   assign clr_we   = (state_q == S_CLEAR);

   // Index wraps modulo WL by keeping only the low log2(WL) bits of the word address
   assign widx    = IW'(WA >> ADDR_SHIFT);
   assign ridx    = IW'(RA >> ADDR_SHIFT);
   assign wr_acc  = WEN & ~BUSY;
   assign rd_acc  = REN & ~BUSY;
   assign collide = wr_acc & rd_acc & (widx == ridx);

   generate
      for (genvar gi = 0; gi < L; gi++) begin : g_lane
         logic [31:0] mem [WL];
         logic        lane_byp;

         always_ff @(posedge CLK) begin
            if (clr_we)
               mem[cnt_q] <= '0;
            else if (wr_acc && WSTRB[gi])
               mem[widx] <= WD[32*gi +: 32];
         end

         assign lane_byp               = (BYPASS != 0) && collide && WSTRB[gi];
         assign rd_pre[32*gi +: 32]    = lane_byp ? WD[32*gi +: 32] : mem[ridx];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (CLR) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(WL - 1))
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rv1_d = rd_acc;
      rd1_d = rd_acc ? rd_pre : rd1_q;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rd1_q   <= '0;
         rv1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd1_q   <= rd1_d;
         rv1_q   <= rv1_d;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DW-1:0] rd2_q, rd2_d;
         logic          rv2_q, rv2_d;

         always_comb begin
            rv2_d = rv1_q;
            rd2_d = rv1_q ? rd1_q : rd2_q;
         end

         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               rd2_q <= '0;
               rv2_q <= 1'b0;
            end else begin
               rd2_q <= rd2_d;
               rv2_q <= rv2_d;
            end
         end

         assign RD     = rd2_q;
         assign RVALID = rv2_q;
      end else begin : g_lat1
         assign RD     = rd1_q;
         assign RVALID = rv1_q;
      end
   endgenerate

endmodule

// File: tb/tb_ntt_bram_sdp.sv
// Directed bench for ntt_bram_sdp: strobes, collisions, wrap, back-to-back reads,
// clear engine and reset during a clear.
module tb_ntt_bram_sdp;

   localparam int DW     = 128;
   localparam int WL     = 32;
   localparam int AW     = 13;
   localparam int RD_LAT = 1;
   localparam int BYPASS = 1;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          CLR;
   logic          BUSY;
   logic          CLR_DONE;
   logic          WEN;
   logic [3:0]    WSTRB;
   logic [AW-1:0] WA;
   logic [DW-1:0] WD;
   logic          REN;
   logic [AW-1:0] RA;
   logic [DW-1:0] RD;
   logic          RVALID;

   int tests_run    = 0;
   int tests_failed = 0;

   ntt_bram_sdp #(
      .DW(DW), .WL(WL), .AW(AW), .ADDR_SHIFT(2), .RD_LAT(RD_LAT), .BYPASS(BYPASS)
   ) dut (
      .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .BUSY(BUSY), .CLR_DONE(CLR_DONE),
      .WEN(WEN), .WSTRB(WSTRB), .WA(WA), .WD(WD),
      .REN(REN), .RA(RA), .RD(RD), .RVALID(RVALID)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
      WEN = 1'b1; WA = a; WD = d; WSTRB = s;
      tick();
      WEN = 1'b0; WSTRB = '0;
   endtask

   task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      REN = 1'b1; RA = a;
      tick();
      REN = 1'b0;
      repeat (RD_LAT - 1) tick();
      check({tag, "_rv"}, RVALID, 1'b1);
      check(tag, RD, exp);
   endtask

   function automatic logic [DW-1:0] pat(input int i);
      return {32'hC0DE0000 | 32'(i), 32'hBEEF0000 | 32'(i), 32'h12340000 | 32'(i), 32'(i + 1)};
   endfunction

   // Observes a clear already launched on the previous edge, issuing reads every busy cycle
   task automatic run_clear(input int reclr_at, output int busy_n, output int done_n,
                            output int rv_busy, output logic [DW-1:0] inflight_rd);
      busy_n = 0; done_n = 0; rv_busy = 0; inflight_rd = '0;
      while (BUSY && busy_n < 200) begin
         busy_n++;
         if (CLR_DONE) done_n++;
         if (RVALID) begin
            if (busy_n == RD_LAT) inflight_rd = RD;
            else rv_busy++;
         end
         REN = 1'b1;
         RA  = AW'(busy_n * 4);
         CLR = (busy_n == reclr_at);
         tick();
      end
      REN = 1'b0;
      CLR = 1'b0;
   endtask

   logic [DW-1:0] got_a, got_b, tmp;
   int            nv, busy_n, done_n, rv_busy;

   initial begin
      RSTN = 1'b0; CLR = 1'b0; WEN = 1'b0; WSTRB = '0; WA = '0; WD = '0; REN = 1'b0; RA = '0;
      #3;
      check("rst_rd", RD, '0);
      check("rst_rvalid", RVALID, 1'b0);
      check("rst_busy", BUSY, 1'b0);
      check("rst_clr_done", CLR_DONE, 1'b0);
      repeat (2) @(posedge CLK);
      #1 RSTN = 1'b1;
      tick();

      wr(13'h00C, 128'h44443333_22221111_00000000_FFFFFFFF, 4'hF);
      rd_check("basic_w3", 13'h00C, 128'h44443333_22221111_00000000_FFFFFFFF);
      tick();
      check("rvalid_idle", RVALID, 1'b0);

      wr(13'h014, {128{1'b1}}, 4'hF);
      wr(13'h014, '0, 4'b0101);
      rd_check("strobe_0101", 13'h014, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
      wr(13'h014, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 4'b0000);
      rd_check("strobe_none", 13'h014, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);

      // Same-word collision, full strobe
      wr(13'h01C, '0, 4'hF);
      WEN = 1'b1; WA = 13'h01C; WD = {16{8'hA5}}; WSTRB = 4'hF;
      REN = 1'b1; RA = 13'h01C;
      tick();
      WEN = 1'b0; REN = 1'b0; WSTRB = '0;
      repeat (RD_LAT - 1) tick();
      check("coll_full_rv", RVALID, 1'b1);
      check("coll_full", RD, (BYPASS != 0) ? {16{8'hA5}} : 128'h0);
      rd_check("coll_after", 13'h01C, {16{8'hA5}});

      // Same-word collision, partial strobe
      WEN = 1'b1; WA = 13'h01C; WD = {16{8'h5A}}; WSTRB = 4'b0011;
      REN = 1'b1; RA = 13'h01C;
      tick();
      WEN = 1'b0; REN = 1'b0; WSTRB = '0;
      repeat (RD_LAT - 1) tick();
      check("coll_part", RD, (BYPASS != 0) ? 128'hA5A5A5A5_A5A5A5A5_5A5A5A5A_5A5A5A5A
                                           : {16{8'hA5}});
      rd_check("coll_part_after", 13'h01C, 128'hA5A5A5A5_A5A5A5A5_5A5A5A5A_5A5A5A5A);

      // Different words on the same edge
      WEN = 1'b1; WA = 13'h024; WD = 128'h99999999_88888888_77777777_66666666; WSTRB = 4'hF;
      REN = 1'b1; RA = 13'h014;
      tick();
      WEN = 1'b0; REN = 1'b0; WSTRB = '0;
      repeat (RD_LAT - 1) tick();
      check("indep_rd", RD, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
      rd_check("indep_wr", 13'h024, 128'h99999999_88888888_77777777_66666666);

      // Back-to-back reads: two pulses, in order
      nv = 0; got_a = '0; got_b = '0;
      REN = 1'b1; RA = 13'h00C;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 0) RA = 13'h024;
         if (k == 1) REN = 1'b0;
         if (RVALID) begin
            if (nv == 0) got_a = RD; else got_b = RD;
            nv++;
         end
      end
      check("b2b_count", 128'(nv), 128'd2);
      check("b2b_first", got_a, 128'h44443333_22221111_00000000_FFFFFFFF);
      check("b2b_second", got_b, 128'h99999999_88888888_77777777_66666666);

      // Index 32 wraps onto word 0
      wr(13'h000, '0, 4'hF);
      wr(13'h080, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 4'hF);
      rd_check("wrap_w0", 13'h000, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);

      // Fill, then clear; a read issued with CLR is still accepted
      for (int i = 0; i < WL; i++) wr(AW'(i * 4), pat(i), 4'hF);
      CLR = 1'b1; REN = 1'b1; RA = 13'h00C;
      tick();
      CLR = 1'b0; REN = 1'b0;
      check("clr_busy_rise", BUSY, 1'b1);
      run_clear(5, busy_n, done_n, rv_busy, tmp);
      check("clr_busy_len", 128'(busy_n), 128'(WL + 1));
      check("clr_done_cnt", 128'(done_n), 128'd1);
      check("clr_rv_busy", 128'(rv_busy), 128'd0);
      check("clr_inflight", tmp, pat(3));
      check("clr_done_low", CLR_DONE, 1'b0);
      tick(); tick();
      check("clr_no_restart", BUSY, 1'b0);
      for (int i = 0; i < WL; i++) rd_check($sformatf("zero_w%0d", i), AW'(i * 4), '0);

      // Reset in the middle of a clear
      wr(13'h008, 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD, 4'hF);
      CLR = 1'b1; REN = 1'b1; RA = 13'h008;
      tick();
      CLR = 1'b0; REN = 1'b0;
      repeat (RD_LAT - 1) tick();
      check("mid_rd_pre", RD, 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD);
      repeat (WL / 2) tick();
      check("mid_busy_pre", BUSY, 1'b1);
      #2 RSTN = 1'b0;
      #1;
      check("mid_rst_busy", BUSY, 1'b0);
      check("mid_rst_rvalid", RVALID, 1'b0);
      check("mid_rst_rd", RD, '0);
      check("mid_rst_done", CLR_DONE, 1'b0);
      #2 RSTN = 1'b1;
      tick();
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      run_clear(0, busy_n, done_n, rv_busy, tmp);
      check("reclr_busy_len", 128'(busy_n), 128'(WL + 1));
      check("reclr_done_cnt", 128'(done_n), 128'd1);
      rd_check("reclr_w2", 13'h008, '0);
      rd_check("reclr_w31", 13'h07C, '0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
